// File: rtl/cm_pkg.sv
// Shared constants for the colour matrix pipeline: default widths, blend
// encodings, coefficient indices and the identity bank.
package cm_pkg;
    localparam int CM_CW     = 6;
    localparam int CM_COEF_W = 10;
    localparam int CM_FRAC   = 7;
    localparam int CM_NCOEF  = 9;

    localparam logic [1:0] BLEND_OFF = 2'd0;
    localparam logic [1:0] BLEND_25  = 2'd1;
    localparam logic [1:0] BLEND_50  = 2'd2;
    localparam logic [1:0] BLEND_75  = 2'd3;

    // Row-major: row = output channel, column = input channel (r,g,b).
    localparam int CM_RR = 0;
    localparam int CM_RG = 1;
    localparam int CM_RB = 2;
    localparam int CM_GR = 3;
    localparam int CM_GG = 4;
    localparam int CM_GB = 5;
    localparam int CM_BR = 6;
    localparam int CM_BG = 7;
    localparam int CM_BB = 8;

    function automatic int cm_ident(input int idx, input int frac);
        return (idx == CM_RR || idx == CM_GG || idx == CM_BB) ? (1 << frac) : 0;
    endfunction
endpackage

// File: rtl/cm_mac_row.sv
// One output row of the colour matrix: three registered signed products,
// then a registered round / arithmetic-shift / clamp of their sum.
module cm_mac_row
    import cm_pkg::*;
#(
    parameter int CW     = CM_CW,
    parameter int COEF_W = CM_COEF_W,
    parameter int FRAC   = CM_FRAC
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [2:0][COEF_W-1:0] i_coef,
    input  logic [2:0][CW-1:0]     i_ch,
    output logic [CW-1:0]          o_pix
);
    localparam int PW = COEF_W + CW + 1;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] RND = SW'(2 ** (FRAC - 1));

    logic [2:0][PW-1:0]   w_prod;
    logic [2:0][PW-1:0]   r_prod;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_shr;
    logic [CW-1:0]        r_pix;

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            w_prod[j] = PW'($signed(i_coef[j])) * PW'($signed({1'b0, i_ch[j]}));
        end
    end

    always_comb begin
        w_sum = RND;
        for (int j = 0; j < 3; j++) begin
            w_sum = w_sum + SW'($signed(r_prod[j]));
        end
        w_shr = w_sum >>> FRAC;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prod <= '0;
            r_pix  <= '0;
        end else begin
            r_prod <= w_prod;
            if (w_shr[SW-1])
                r_pix <= '0;
            else if (|w_shr[SW-2:CW])
                r_pix <= '1;
            else
                r_pix <= w_shr[CW-1:0];
        end
    end

    assign o_pix = r_pix;
endmodule

// File: rtl/color_matrix_pipe.sv
// Previous-frame blend followed by a programmable 3x3 colour matrix; settings
// are double-buffered and committed on the vsync rising edge.
module color_matrix_pipe
    import cm_pkg::*;
#(
    parameter int CW     = CM_CW,
    parameter int COEF_W = CM_COEF_W,
    parameter int FRAC   = CM_FRAC
) (
    input  logic              hClk,
    input  logic              nRST,
    input  logic              hValid,
    input  logic              hHsync,
    input  logic              hVsync,
    input  logic [3*CW-1:0]   hColorPixel,
    input  logic [3*CW-1:0]   hPrevPixel,
    input  logic [1:0]        blendMode,
    input  logic              correctEnable,
    input  logic              cfgWe,
    input  logic [3:0]        cfgAddr,
    input  logic [COEF_W-1:0] cfgData,
    output logic              cfgPending,
    output logic              hValidOut,
    output logic              hHsyncOut,
    output logic              hVsyncOut,
    output logic [3*CW-1:0]   hColorPixelOut
);
    localparam int STAGES = 3;
    typedef logic [CM_NCOEF-1:0][COEF_W-1:0] bank_t;

    bank_t                        r_shadow, r_act, r_coef_s1;
    logic [1:0]                   r_act_mode;
    logic                         r_act_ce, r_vs_d, r_pend;
    logic [STAGES:1][2:0]         r_ctl_pipe;
    logic [STAGES:1]              r_ce_pipe;
    logic [STAGES:1][2:0][CW-1:0] r_bl_pipe;
    logic [2:0][CW-1:0]           w_cur, w_prev, w_bl, w_mac, w_out;
    logic                         w_commit, w_wr;

    function automatic logic [CW-1:0] blend(input logic [1:0] mode,
                                            input logic [CW-1:0] cur,
                                            input logic [CW-1:0] prev);
        logic [CW+1:0] c, p;
        c = {2'b00, cur};
        p = {2'b00, prev};
        case (mode)
            BLEND_25: return CW'((c + c + c + p) >> 2);
            BLEND_50: return CW'((c + p) >> 1);
            BLEND_75: return CW'((c + p + p + p) >> 2);
            default:  return cur;
        endcase
    endfunction

    assign w_cur    = hColorPixel;
    assign w_prev   = hPrevPixel;
    assign w_commit = hVsync & ~r_vs_d;
    assign w_wr     = cfgWe & (cfgAddr < 4'd9);

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_bl[k] = blend(r_act_mode, w_cur[k], w_prev[k]);
        end
    end

    // Commit reads r_shadow before a same-cycle write lands, so that write stays pending.
    always_ff @(posedge hClk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < CM_NCOEF; i++) begin
                r_shadow[i] <= COEF_W'(cm_ident(i, FRAC));
                r_act[i]    <= COEF_W'(cm_ident(i, FRAC));
            end
            r_act_mode <= BLEND_OFF;
            r_act_ce   <= 1'b0;
            r_pend     <= 1'b0;
            r_vs_d     <= 1'b0;
        end else begin
            if (w_commit) begin
                r_act      <= r_shadow;
                r_act_mode <= blendMode;
                r_act_ce   <= correctEnable;
            end
            if (w_wr)
                r_shadow[cfgAddr] <= cfgData;
            r_pend <= w_wr | (r_pend & ~w_commit);
            r_vs_d <= hVsync;
        end
    end

    // Coefficients and enable travel with the pixel so a commit never splits one.
    always_ff @(posedge hClk or negedge nRST) begin
        if (!nRST) begin
            r_ctl_pipe <= '0;
            r_ce_pipe  <= '0;
            r_bl_pipe  <= '0;
            r_coef_s1  <= '0;
        end else begin
            r_ctl_pipe <= {r_ctl_pipe[STAGES-1:1], {hVsync, hHsync, hValid}};
            r_ce_pipe  <= {r_ce_pipe[STAGES-1:1], r_act_ce};
            r_bl_pipe  <= {r_bl_pipe[STAGES-1:1], w_bl};
            r_coef_s1  <= r_act;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_row
        cm_mac_row #(
            .CW     (CW),
            .COEF_W (COEF_W),
            .FRAC   (FRAC)
        ) u_row (
            .i_clk   (hClk),
            .i_rst_n (nRST),
            .i_coef  (r_coef_s1[3*g+2 -: 3]),
            .i_ch    (r_bl_pipe[1]),
            .o_pix   (w_mac[g])
        );
    end

    assign w_out          = r_ce_pipe[STAGES] ? w_mac : r_bl_pipe[STAGES];
    assign hColorPixelOut = w_out;
    assign {hVsyncOut, hHsyncOut, hValidOut} = r_ctl_pipe[STAGES];
    assign cfgPending     = r_pend;
endmodule

// File: tb/tb_color_matrix_pipe.sv
// Directed bench for color_matrix_pipe: a per-cycle reference model of the
// blend/matrix/commit rules plus hand-computed pixel expectations.
module tb_color_matrix_pipe;
    logic        hClk = 1'b0;
    logic        nRST = 1'b0;
    logic        hValid = 1'b0, hHsync = 1'b0, hVsync = 1'b0;
    logic [17:0] hColorPixel = '0, hPrevPixel = '0;
    logic [1:0]  blendMode = '0;
    logic        correctEnable = 1'b0, cfgWe = 1'b0;
    logic [3:0]  cfgAddr = '0;
    logic [9:0]  cfgData = '0;
    logic        cfgPending, hValidOut, hHsyncOut, hVsyncOut;
    logic [17:0] hColorPixelOut;

    int total = 0;
    int bad   = 0;

    // Reference model state (fixed CW=6, COEF_W=10, FRAC=7)
    int          m_sh[9];
    int          m_act[9];
    int          m_mode;
    bit          m_ce, m_vsd, m_pend;
    logic [20:0] m_pipe[3];

    color_matrix_pipe dut (
        .hClk(hClk), .nRST(nRST), .hValid(hValid), .hHsync(hHsync), .hVsync(hVsync),
        .hColorPixel(hColorPixel), .hPrevPixel(hPrevPixel), .blendMode(blendMode),
        .correctEnable(correctEnable), .cfgWe(cfgWe), .cfgAddr(cfgAddr), .cfgData(cfgData),
        .cfgPending(cfgPending), .hValidOut(hValidOut), .hHsyncOut(hHsyncOut),
        .hVsyncOut(hVsyncOut), .hColorPixelOut(hColorPixelOut)
    );

    always #5 hClk = ~hClk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic logic [17:0] px(input int b, input int g, input int r);
        return {b[5:0], g[5:0], r[5:0]};
    endfunction

    function automatic logic [17:0] model_pix(input logic [17:0] cur, input logic [17:0] prev,
                                              input int mode, input bit ce, input int k[9]);
        int bl[3];
        int x, y, s, v;
        logic [17:0] res;
        for (int c = 0; c < 3; c++) begin
            x = int'(cur[6*c +: 6]);
            y = int'(prev[6*c +: 6]);
            case (mode)
                0:       bl[c] = x;
                1:       bl[c] = (3 * x + y) / 4;
                2:       bl[c] = (x + y) / 2;
                default: bl[c] = (x + 3 * y) / 4;
            endcase
        end
        res = '0;
        for (int row = 0; row < 3; row++) begin
            if (!ce) v = bl[row];
            else begin
                s = k[3*row] * bl[0] + k[3*row+1] * bl[1] + k[3*row+2] * bl[2];
                v = (s + 64) >>> 7;
                if (v < 0) v = 0;
                if (v > 63) v = 63;
            end
            res[6*row +: 6] = v[5:0];
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_sh[i]  = (i == 0 || i == 4 || i == 8) ? 128 : 0;
            m_act[i] = m_sh[i];
        end
        m_mode = 0; m_ce = 0; m_vsd = 0; m_pend = 0;
        for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    endtask

    // Advance the model by the clock edge that will sample the present inputs.
    task automatic model_step();
        logic [20:0] e;
        int d;
        e = {hVsync, hHsync, hValid, model_pix(hColorPixel, hPrevPixel, m_mode, m_ce, m_act)};
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = e;
        if (hVsync && !m_vsd) begin
            for (int i = 0; i < 9; i++) m_act[i] = m_sh[i];
            m_mode = int'(blendMode);
            m_ce   = correctEnable;
            m_pend = 0;
        end
        if (cfgWe && cfgAddr < 9) begin
            d = int'($signed(cfgData));
            m_sh[cfgAddr] = d;
            m_pend = 1;
        end
        m_vsd = hVsync;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge hClk);
            if (!nRST) model_reset();
            chk("model", {cfgPending, hVsyncOut, hHsyncOut, hValidOut, hColorPixelOut},
                {m_pend, m_pipe[2]});
            if (nRST) model_step();
        end
    end

    task automatic step();
        @(posedge hClk);
        #2;
    endtask

    task automatic commit(input int mode, input bit ce);
        blendMode = mode[1:0];
        correctEnable = ce;
        hVsync = 1'b1;
        step();
        hVsync = 1'b0;
        step();
    endtask

    task automatic wr(input int a, input int d);
        cfgWe = 1'b1;
        cfgAddr = a[3:0];
        cfgData = d[9:0];
        step();
        cfgWe = 1'b0;
    endtask

    task automatic run_pix(input string nm, input logic [17:0] cur, input logic [17:0] prev,
                           input bit hs, input logic [17:0] want);
        hColorPixel = cur; hPrevPixel = prev; hValid = 1'b1; hHsync = hs;
        step();
        hColorPixel = '0; hPrevPixel = '0; hValid = 1'b0; hHsync = 1'b0;
        step();
        chk({nm, "_early"}, hValidOut, 0);
        step();
        chk(nm, hColorPixelOut, want);
        chk({nm, "_v"}, hValidOut, 1);
        chk({nm, "_hs"}, hHsyncOut, hs);
    endtask

    initial begin
        step(); step();
        chk("rst_pix", hColorPixelOut, 0);
        chk("rst_pend", cfgPending, 0);
        chk("rst_v", hValidOut, 0);
        nRST = 1'b1;
        step();

        commit(0, 1);
        run_pix("ident", px(63, 32, 1), '0, 1'b1, px(63, 32, 1));

        commit(2, 1); run_pix("blend50", px(0, 0, 40), px(0, 0, 20), 1'b0, px(0, 0, 30));
        commit(1, 1); run_pix("blend25", px(0, 0, 40), px(0, 0, 20), 1'b0, px(0, 0, 35));
        commit(3, 1); run_pix("blend75", px(0, 0, 40), px(0, 0, 20), 1'b0, px(0, 0, 25));
        commit(0, 1); run_pix("blend0",  px(0, 0, 40), px(0, 0, 20), 1'b0, px(0, 0, 40));

        wr(0, 511);
        chk("pend_set", cfgPending, 1);
        commit(0, 1);
        chk("pend_clr", cfgPending, 0);
        run_pix("sat_hi", px(0, 0, 63), '0, 1'b0, px(0, 0, 63));
        wr(0, -128); commit(0, 1);
        run_pix("sat_lo", px(0, 0, 63), '0, 1'b0, px(0, 0, 0));
        wr(0, 128); commit(0, 1);

        wr(4, 64);
        chk("mid_pend", cfgPending, 1);
        run_pix("mid_hold", px(0, 40, 0), '0, 1'b0, px(0, 40, 0));
        commit(0, 1);
        chk("mid_clr", cfgPending, 0);
        run_pix("gg_half", px(0, 40, 0), '0, 1'b0, px(0, 20, 0));

        cfgWe = 1'b1; cfgAddr = 4'd4; cfgData = 10'd128; hVsync = 1'b1;
        step();
        cfgWe = 1'b0; hVsync = 1'b0;
        step();
        chk("wr_on_commit", cfgPending, 1);
        run_pix("pre_write_copy", px(0, 40, 0), '0, 1'b0, px(0, 20, 0));
        commit(0, 1);
        run_pix("post_write", px(0, 40, 0), '0, 1'b0, px(0, 40, 0));

        wr(0, 256); commit(2, 0);
        run_pix("bypass", px(10, 20, 40), px(30, 0, 20), 1'b0, px(20, 10, 30));
        wr(12, 0);
        chk("bad_addr_pend", cfgPending, 0);
        commit(0, 1);
        run_pix("bad_addr_bank", px(1, 20, 3), '0, 1'b0, px(1, 20, 6));

        wr(1, 300);
        hValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hColorPixel = px(5, 5, 5 + i);
            step();
        end
        chk("inflight_v", hValidOut, 1);
        nRST = 1'b0;
        #1;
        chk("async_v", hValidOut, 0);
        chk("async_pix", hColorPixelOut, 0);
        chk("async_pend", cfgPending, 0);
        hValid = 1'b0; hColorPixel = '0;
        step();
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_v", hValidOut, 0);
        end
        commit(0, 1);
        run_pix("ident_restored", px(9, 8, 7), '0, 1'b0, px(9, 8, 7));

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
